// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, oversampling
// constants and small helpers for frame length and parity evaluation.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;

    // Sample-counter values at which a strobe fires (counter runs 0..15)
    localparam logic [3:0] LAST_OS_TICK  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_MID_TICK = 4'(MID_SAMPLE - 1);

    // Number of data bits for the 2-bit encoding 00=5 .. 11=8
    function automatic logic [3:0] data_bits(input logic [1:0] enc);
        return 4'd5 + {2'b00, enc};
    endfunction

    // True when data plus received parity bit disagree with the selected sense
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       pbit,
                                             input logic       odd);
        return ((^data) ^ pbit) != odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
// Ports: clk/reset_n (sync active-low), i_reload restarts the period,
// i_div sets the period to i_div+1 clocks, o_tick is a one-clock strobe.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_reload,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == i_div);
    assign o_tick = w_wrap;

    // Free-running divisor counter, restarted on reload
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= {DIV_W{1'b0}};
        end else if (i_reload) begin
            r_cnt <= {DIV_W{1'b0}};
        end else if (w_wrap) begin
            r_cnt <= {DIV_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: 16x oversampled, 5-8 data bits, optional parity,
// 1 or 2 stop bits, single holding register with RTS-style flow control.
// Ports: clk, reset_n (sync active-low), rx serial line, cfg_* frame format
// and divisor, rx_ack from the consumer; rx_data/rx_done/parity_error/
// framing_error per completed frame, overrun_error when data was unread,
// rts_n high while the holding register is full.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_odd,
    input  logic             cfg_stop2,
    input  logic             rx_ack,
    output logic [7:0]       rx_data,
    output logic             rx_done,
    output logic             parity_error,
    output logic             framing_error,
    output logic             overrun_error,
    output logic             rts_n
);

    rx_state_e              r_state;
    rx_state_e              w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    logic                   w_tick;
    logic                   w_reload;
    logic                   w_complete;
    logic                   w_mid_strobe;
    logic                   w_bit_strobe;
    logic [2:0]             w_last_idx;
    logic [3:0]             r_scnt;
    logic [2:0]             r_bcnt;
    logic [7:0]             r_shift;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_second;
    logic                   r_fin;
    logic [7:0]             r_rx_data;
    logic                   r_rx_done;
    logic                   r_parity_error;
    logic                   r_framing_error;
    logic                   r_overrun;
    logic                   r_hold;

    assign w_rxs        = r_sync[SYNC_STAGES-1];
    assign w_mid_strobe = w_tick && (r_scnt == LAST_MID_TICK);
    assign w_bit_strobe = w_tick && (r_scnt == LAST_OS_TICK);
    assign w_last_idx   = 3'(data_bits(cfg_data_bits) - 4'd1);

    assign rx_data       = r_rx_data;
    assign rx_done       = r_rx_done;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;
    assign overrun_error = r_overrun;
    assign rts_n         = r_hold;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_reload (w_reload),
        .i_div    (cfg_div),
        .o_tick   (w_tick)
    );

    // rx input synchronizer, idles high
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{1'b1}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state plus reload/complete strobes
    always_comb begin
        w_state_nxt = r_state;
        w_reload    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = START;
                    w_reload    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (w_mid_strobe) begin
                    w_state_nxt = w_rxs ? IDLE : DATA;
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                if (w_bit_strobe && (r_bcnt == w_last_idx)) begin
                    w_state_nxt = cfg_parity_en ? PARITY : STOP;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            PARITY: begin
                if (w_bit_strobe) begin
                    w_state_nxt = STOP;
                end else begin
                    w_state_nxt = PARITY;
                end
            end
            STOP: begin
                // r_fin marks that the last stop bit was sampled last clock
                if (r_fin) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bit sampling datapath: sample counter, shift register, error capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scnt   <= 4'd0;
            r_bcnt   <= 3'd0;
            r_shift  <= 8'd0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_second <= 1'b0;
            r_fin    <= 1'b0;
        end else if (w_reload) begin
            r_scnt   <= 4'd0;
            r_bcnt   <= 3'd0;
            r_shift  <= 8'd0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_second <= 1'b0;
            r_fin    <= 1'b0;
        end else begin
            // Realign to mid-bit after the start check; later strobes wrap 15->0
            if ((r_state == START) && w_mid_strobe) begin
                r_scnt <= 4'd0;
            end else if (w_tick) begin
                r_scnt <= r_scnt + 4'd1;
            end
            if ((r_state == DATA) && w_bit_strobe) begin
                r_shift[r_bcnt] <= w_rxs;
                r_bcnt          <= r_bcnt + 3'd1;
            end
            // Unused upper shift bits stay 0, so ^r_shift covers only data bits
            if ((r_state == PARITY) && w_bit_strobe) begin
                r_perr <= parity_mismatch(r_shift, w_rxs, cfg_parity_odd);
            end
            if ((r_state == STOP) && w_bit_strobe && !r_fin) begin
                if (!w_rxs) begin
                    r_ferr <= 1'b1;
                end
                if (cfg_stop2 && !r_second) begin
                    r_second <= 1'b1;
                end else begin
                    r_fin <= 1'b1;
                end
            end
            if (w_complete) begin
                r_fin <= 1'b0;
            end
        end
    end

    // Holding register, completion pulses and flow-control flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_data       <= 8'd0;
            r_rx_done       <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
            r_hold          <= 1'b0;
        end else begin
            r_rx_done       <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
            if (w_complete) begin
                // An ack in the same cycle frees the register before the load
                if (r_hold && !rx_ack) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_rx_data       <= r_shift;
                    r_rx_done       <= 1'b1;
                    r_parity_error  <= r_perr;
                    r_framing_error <= r_ferr;
                    r_hold          <= 1'b1;
                end
            end else if (rx_ack) begin
                r_hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized
// frames compared against a frame-level reference model.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] cfg_div = 16'd0;
    logic [1:0]  cfg_data_bits = 2'b11;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        cfg_stop2 = 1'b0;
    logic        rx_ack = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        parity_error;
    logic        framing_error;
    logic        overrun_error;
    logic        rts_n;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    rec_t mon_q[$];
    int   ovr_cnt = 0;

    uart_rx_core dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx             (rx),
        .cfg_div        (cfg_div),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_ack         (rx_ack),
        .rx_data        (rx_data),
        .rx_done        (rx_done),
        .parity_error   (parity_error),
        .framing_error  (framing_error),
        .overrun_error  (overrun_error),
        .rts_n          (rts_n)
    );

    always #5 clk = ~clk;

    // Record every completion event seen on the outputs
    always @(negedge clk) begin
        if (rx_done) mon_q.push_back({rx_data, parity_error, framing_error});
        if (overrun_error) ovr_cnt++;
    end

    // ---------------- reference model helpers ----------------
    function automatic int nbits_of(input logic [1:0] enc);
        return 5 + int'(enc);
    endfunction

    function automatic logic [7:0] masked(input logic [7:0] d, input int n);
        return 8'(int'(d) % (1 << n));
    endfunction

    // Parity bit value that makes the frame correct
    function automatic logic good_parity(input logic [7:0] d, input int n, input logic odd);
        return logic'(($countones(masked(d, n)) + int'(odd)) % 2);
    endfunction

    function automatic logic exp_perr(input logic [7:0] d, input int n, input logic pbit, input logic odd);
        return logic'((($countones(masked(d, n)) + int'(pbit)) % 2) != int'(odd));
    endfunction

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b);
        rx = b;
        repeat (16 * (int'(cfg_div) + 1)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
        int n;
        n = nbits_of(cfg_data_bits);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(d[i]);
        if (cfg_parity_en) send_bit(pbit);
        send_bit(s1);
        if (cfg_stop2) send_bit(s2);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] dv, input logic [1:0] db, input logic pe,
                           input logic po, input logic s2);
        cfg_div = dv; cfg_data_bits = db; cfg_parity_en = pe; cfg_parity_odd = po; cfg_stop2 = s2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        n_checks++;
        if ({rx_done, parity_error, framing_error, overrun_error} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_flags got %b want 0000", {rx_done, parity_error, framing_error, overrun_error});
        end
        n_checks++;
        if (rts_n !== 1'b0) begin n_errors++; $display("FAIL reset_rts_n got %b want 0", rts_n); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_8n1();
        mon_q.delete();
        set_cfg(16'd0, 2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (mon_q.size() != 1) begin n_errors++; $display("FAIL basic_count got %0d want 1", mon_q.size()); end
        else begin
            n_checks++;
            if (mon_q[0] !== {8'hA5, 1'b0, 1'b0}) begin
                n_errors++; $display("FAIL basic_frame got %h/%b/%b want a5/0/0", mon_q[0].d, mon_q[0].pe, mon_q[0].fe);
            end
        end
        n_checks++;
        if (rts_n !== 1'b1) begin n_errors++; $display("FAIL basic_rts_full got %b want 1", rts_n); end
        do_ack();
        n_checks++;
        if (rts_n !== 1'b0) begin n_errors++; $display("FAIL basic_rts_ack got %b want 0", rts_n); end
    endtask

    task automatic test_parity();
        set_cfg(16'd1, 2'b11, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            logic pb;
            pb = (k == 0) ? 1'b1 : 1'b0;
            mon_q.delete();
            send_frame(8'h3C, pb, 1'b1, 1'b1);
            n_checks++;
            if (mon_q.size() != 1) begin n_errors++; $display("FAIL parity_count[%0d] got %0d want 1", k, mon_q.size()); end
            else begin
                n_checks++;
                if (mon_q[0] !== {8'h3C, pb, 1'b0}) begin
                    n_errors++; $display("FAIL parity_frame[%0d] got %h/%b/%b want 3c/%b/0", k, mon_q[0].d, mon_q[0].pe, mon_q[0].fe, pb);
                end
            end
            do_ack();
        end
    endtask

    task automatic test_framing();
        mon_q.delete();
        set_cfg(16'd2, 2'b10, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (mon_q.size() != 1) begin n_errors++; $display("FAIL framing_count got %0d want 1", mon_q.size()); end
        else begin
            n_checks++;
            if (mon_q[0] !== {8'h55, 1'b0, 1'b1}) begin
                n_errors++; $display("FAIL framing_frame got %h/%b/%b want 55/0/1", mon_q[0].d, mon_q[0].pe, mon_q[0].fe);
            end
        end
        do_ack();
    endtask

    task automatic test_glitch();
        int ovr0;
        mon_q.delete();
        ovr0 = ovr_cnt;
        set_cfg(16'd2, 2'b11, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (4 * 3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * 16 * 3) @(negedge clk);
        n_checks++;
        if (mon_q.size() != 0 || ovr_cnt != ovr0) begin
            n_errors++; $display("FAIL glitch_no_event got %0d frames %0d overruns want 0 0", mon_q.size(), ovr_cnt - ovr0);
        end
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (mon_q.size() != 1 || mon_q[0].d !== 8'h5A) begin
            n_errors++; $display("FAIL glitch_recover got %0d frames want 1 frame of 5a", mon_q.size());
        end
        do_ack();
    endtask

    task automatic test_overrun();
        int ovr0;
        mon_q.delete();
        ovr0 = ovr_cnt;
        set_cfg(16'd0, 2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (mon_q.size() != 1 || mon_q[0].d !== 8'h11) begin
            n_errors++; $display("FAIL overrun_first got %0d frames want 1 frame of 11", mon_q.size());
        end
        n_checks++;
        if (ovr_cnt - ovr0 != 1) begin n_errors++; $display("FAIL overrun_pulse got %0d want 1", ovr_cnt - ovr0); end
        n_checks++;
        if (rx_data !== 8'h11) begin n_errors++; $display("FAIL overrun_keep got %h want 11", rx_data); end
        n_checks++;
        if (rts_n !== 1'b1) begin n_errors++; $display("FAIL overrun_rts got %b want 1", rts_n); end
    endtask

    task automatic test_reset_mid();
        // holding flag is still set from the overrun test
        set_cfg(16'd1, 2'b11, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rx_data !== 8'h00 || rts_n !== 1'b0) begin
            n_errors++; $display("FAIL midreset_outputs got %h/%b want 00/0", rx_data, rts_n);
        end
        reset_n = 1'b1;
        mon_q.delete();
        rx = 1'b1;
        repeat (3 * 16 * 2) @(negedge clk);
        n_checks++;
        if (mon_q.size() != 0) begin n_errors++; $display("FAIL midreset_quiet got %0d want 0", mon_q.size()); end
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (mon_q.size() != 1 || mon_q[0] !== {8'h0F, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL midreset_next got %0d frames want 1 frame of 0f", mon_q.size());
        end
    endtask

    task automatic test_random();
        logic       hold;
        logic [7:0] last;
        hold = 1'b1;
        last = 8'h00;
        for (int it = 0; it < 20; it++) begin
            logic [7:0] d, ed;
            logic       pb, s1, s2, epe, efe;
            int         n, ovr0;
            set_cfg(16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n  = nbits_of(cfg_data_bits);
            d  = 8'($urandom_range(0, 255));
            pb = good_parity(d, n, cfg_parity_odd) ^ ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 3) != 0);
            s2 = ($urandom_range(0, 3) != 0);
            if (it == 0 || $urandom_range(0, 1) == 1) begin
                do_ack();
                hold = 1'b0;
            end
            ed  = masked(d, n);
            epe = cfg_parity_en ? exp_perr(d, n, pb, cfg_parity_odd) : 1'b0;
            efe = !s1 || (cfg_stop2 && !s2);
            mon_q.delete();
            ovr0 = ovr_cnt;
            send_frame(d, pb, s1, s2);
            if (!hold) begin
                n_checks++;
                if (mon_q.size() != 1 || mon_q[0] !== {ed, epe, efe} || ovr_cnt != ovr0) begin
                    n_errors++;
                    $display("FAIL rand_frame[%0d] got %0d frames %h/%b/%b want %h/%b/%b", it, mon_q.size(),
                             (mon_q.size() > 0) ? mon_q[0].d : 8'h00, (mon_q.size() > 0) ? mon_q[0].pe : 1'b0,
                             (mon_q.size() > 0) ? mon_q[0].fe : 1'b0, ed, epe, efe);
                end
                hold = 1'b1;
                last = ed;
            end else begin
                n_checks++;
                if (mon_q.size() != 0 || ovr_cnt - ovr0 != 1 || rx_data !== last) begin
                    n_errors++;
                    $display("FAIL rand_overrun[%0d] got %0d frames %0d overruns data %h want 0 1 %h",
                             it, mon_q.size(), ovr_cnt - ovr0, rx_data, last);
                end
            end
            n_checks++;
            if (rts_n !== hold) begin n_errors++; $display("FAIL rand_rts[%0d] got %b want %b", it, rts_n, hold); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_8n1();
        test_parity();
        test_framing();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
